csi_tx_packetizer: RTL

Two-lane MIPI CSI-2 transmit packetizer: the byte-domain counterpart of the CSI-2 receive word aligner. It turns frame-start/frame-end requests and an AXI-Stream line of pixel bytes into per-lane HS byte streams: sync byte, packet header with ECC, payload, CRC-16 and HS trail, with an LP gap between packets. It sits between the pixel source and the per-lane serializer PHYs, and runs in the byte clock domain (same clock as the serializer's divided clock).

---
 rtl/csi_tx_packetizer_if.sv | 20 ++
 rtl/csi_tx_packetizer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_tx_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module      : csi_tx_packetizer_if
// Description : AXI-Stream style pixel-word channel into the CSI-2 TX
//               packetizer. tdata[7:0] is the earlier byte, tdata[15:8] the
//               later one. A word moves when tvalid and tready are both high.
//               master : pixel source     (drives tdata/tvalid/tlast)
//               slave  : packetizer       (drives tready)
// Revision    : 1.0 - initial release
// ============================================================================
interface csi_tx_packetizer_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/csi_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : csi_tx_packetizer
// Description : Two-lane MIPI CSI-2 transmit packetizer (byte clock domain).
//               Emits FS/FE short packets and long pixel packets as per-lane
//               HS byte streams: sync, header + ECC, payload, CRC-16, trail,
//               followed by GAP_CYCLES of HS-off.
// Ports       : clk, rst       - byte clock, synchronous active-high reset
//               frame_start/end- one-cycle FS/FE requests (latched)
//               s_axis         - pixel word channel (slave modport)
//               hs_en          - lanes in HS mode
//               lane0/1_data   - bytes to the lane serializers
//               busy           - state is not IDLE
//               frame_num      - frame number of the latest FS/FE
//               underrun       - sticky: payload word missing in PAYLOAD
//               len_err        - sticky: tlast position disagrees with length
// Revision    : 1.0 - initial release
// ============================================================================
module csi_tx_packetizer #(
    parameter logic [7:0]  DATA_TYPE  = 8'h2A,
    parameter logic [1:0]  VC         = 2'd0,
    parameter logic [15:0] WORD_COUNT = 16'd1280,
    parameter int          GAP_CYCLES = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               frame_start,
    input  wire logic               frame_end,
    csi_tx_packetizer_if.slave      s_axis,
    output logic                    hs_en,
    output logic [7:0]              lane0_data,
    output logic [7:0]              lane1_data,
    output logic                    busy,
    output logic [15:0]             frame_num,
    output logic                    underrun,
    output logic                    len_err
);

    // r_state names the packet phase currently shown on the lanes.
    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_SOT     = 3'd1;
    localparam logic [2:0] c_HDR0    = 3'd2;
    localparam logic [2:0] c_HDR1    = 3'd3;
    localparam logic [2:0] c_PAYLOAD = 3'd4;
    localparam logic [2:0] c_CRC     = 3'd5;
    localparam logic [2:0] c_TRAIL   = 3'd6;
    localparam logic [2:0] c_GAP     = 3'd7;

    localparam logic [15:0] c_WORD_LAST = (WORD_COUNT >> 1) - 16'd1;
    localparam logic [15:0] c_GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [7:0]  c_SYNC      = 8'hB8;

    function automatic logic [7:0] f_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = (^d[19:10])^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    // Reflected CCITT polynomial, data shifted in LSB first.
    function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    logic [2:0]  r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_gap, w_gap_nxt;
    logic [15:0] r_crc, w_crc_nxt;
    logic [5:0]  r_dt, w_dt_nxt;
    logic [15:0] r_wc, w_wc_nxt;
    logic        r_long, w_long_nxt;
    logic        r_fs_pend, r_fe_pend, r_tready;
    logic [15:0] w_frame_nxt;
    logic [7:0]  w_lane0_nxt, w_lane1_nxt, w_di;
    logic        w_fs_req, w_fe_req, w_fs_take, w_fe_take, w_load;
    logic [15:0] w_word;

    assign s_axis.tready = r_tready;
    assign w_fs_req      = r_fs_pend | frame_start;
    assign w_fe_req      = r_fe_pend | frame_end;
    assign w_di          = {VC, r_dt};
    // Missing source data is replaced with zero bytes so HS timing never stalls.
    assign w_word        = s_axis.tvalid ? s_axis.tdata : 16'h0000;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_crc_nxt   = r_crc;
        w_dt_nxt    = r_dt;
        w_wc_nxt    = r_wc;
        w_long_nxt  = r_long;
        w_frame_nxt = frame_num;
        w_lane0_nxt = 8'h00;
        w_lane1_nxt = 8'h00;
        w_fs_take   = 1'b0;
        w_fe_take   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_fs_req) begin
                    w_fs_take   = 1'b1;
                    // Frame number skips 0 on wrap.
                    w_frame_nxt = (frame_num == 16'hFFFF) ? 16'd1 : frame_num + 16'd1;
                    w_dt_nxt    = 6'h00;
                    w_wc_nxt    = w_frame_nxt;
                    w_long_nxt  = 1'b0;
                    w_state_nxt = c_SOT;
                end else if (s_axis.tvalid) begin
                    w_dt_nxt    = DATA_TYPE[5:0];
                    w_wc_nxt    = WORD_COUNT;
                    w_long_nxt  = 1'b1;
                    w_state_nxt = c_SOT;
                end else if (w_fe_req) begin
                    w_fe_take   = 1'b1;
                    w_dt_nxt    = 6'h01;
                    w_wc_nxt    = frame_num;
                    w_long_nxt  = 1'b0;
                    w_state_nxt = c_SOT;
                end
                if (w_state_nxt == c_SOT) begin
                    w_lane0_nxt = c_SYNC;
                    w_lane1_nxt = c_SYNC;
                    w_crc_nxt   = 16'hFFFF;
                end
            end
            c_SOT: begin
                w_state_nxt = c_HDR0;
                w_lane0_nxt = w_di;
                w_lane1_nxt = r_wc[7:0];
            end
            c_HDR0: begin
                w_state_nxt = c_HDR1;
                w_lane0_nxt = r_wc[15:8];
                w_lane1_nxt = f_ecc({r_wc, w_di});
            end
            c_HDR1: begin
                if (r_long) begin
                    w_state_nxt = c_PAYLOAD;
                    w_cnt_nxt   = 16'd0;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = c_TRAIL;
                    w_lane0_nxt = {8{~lane0_data[7]}};
                    w_lane1_nxt = {8{~lane1_data[7]}};
                end
            end
            c_PAYLOAD: begin
                if (r_cnt == c_WORD_LAST) begin
                    w_state_nxt = c_CRC;
                    w_lane0_nxt = r_crc[7:0];
                    w_lane1_nxt = r_crc[15:8];
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                    w_load    = 1'b1;
                end
            end
            c_CRC: begin
                w_state_nxt = c_TRAIL;
                w_lane0_nxt = {8{~lane0_data[7]}};
                w_lane1_nxt = {8{~lane1_data[7]}};
            end
            c_TRAIL: begin
                w_state_nxt = c_GAP;
                w_gap_nxt   = 16'd0;
            end
            default: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_gap_nxt = r_gap + 16'd1;
                end
            end
        endcase
        // Each load edge consumes the word offered under the registered tready.
        if (w_load) begin
            w_lane0_nxt = w_word[7:0];
            w_lane1_nxt = w_word[15:8];
            w_crc_nxt   = f_crc_byte(f_crc_byte(r_crc, w_word[7:0]), w_word[15:8]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= 16'd0;
            r_gap      <= 16'd0;
            r_crc      <= 16'hFFFF;
            r_dt       <= 6'h00;
            r_wc       <= 16'd0;
            r_long     <= 1'b0;
            r_fs_pend  <= 1'b0;
            r_fe_pend  <= 1'b0;
            r_tready   <= 1'b0;
            hs_en      <= 1'b0;
            lane0_data <= 8'h00;
            lane1_data <= 8'h00;
            busy       <= 1'b0;
            frame_num  <= 16'd0;
            underrun   <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gap      <= w_gap_nxt;
            r_crc      <= w_crc_nxt;
            r_dt       <= w_dt_nxt;
            r_wc       <= w_wc_nxt;
            r_long     <= w_long_nxt;
            r_fs_pend  <= w_fs_req & ~w_fs_take;
            r_fe_pend  <= w_fe_req & ~w_fe_take;
            // tready leads the payload lanes by one cycle so that a word
            // accepted at one edge is on the lanes right after it.
            r_tready   <= ((w_state_nxt == c_HDR1) && w_long_nxt) ||
                          ((w_state_nxt == c_PAYLOAD) && (w_cnt_nxt != c_WORD_LAST));
            hs_en      <= (w_state_nxt != c_IDLE) && (w_state_nxt != c_GAP);
            lane0_data <= w_lane0_nxt;
            lane1_data <= w_lane1_nxt;
            busy       <= (w_state_nxt != c_IDLE);
            frame_num  <= w_frame_nxt;
            if (w_load && !s_axis.tvalid) begin
                underrun <= 1'b1;
            end
            if (w_load && s_axis.tvalid && (s_axis.tlast != (w_cnt_nxt == c_WORD_LAST))) begin
                len_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
